// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clock/reset sequencer: sequencer states and
// the default clock-enable accumulator constants.
package clk_rst_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } seq_state_e;

   // 2796 / 65536 * 46.875 MHz is approximately 2.0 MHz
   localparam int unsigned ACC_W_DEF  = 16;
   localparam int unsigned CE_INC_DEF = 2796;

endpackage

// File: rtl/clk_ce_gen.sv
// Phase-accumulator clock-enable generator. While en_i is high the
// accumulator adds CE_INC modulo 2^ACC_W every cycle and ce_o is high for
// the one cycle after each carry-out. While en_i is low the accumulator is
// held at zero and ce_o is low.
module clk_ce_gen
   import clk_rst_pkg::*;
#(
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned CE_INC = CE_INC_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic ce_o
);

   localparam logic [ACC_W-1:0] INC = ACC_W'(CE_INC);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic             ce_q;
   logic             ce_d;

   // next accumulator value and carry; disabled accumulator parks at zero
   always_comb begin
      acc_d = '0;
      ce_d  = 1'b0;
      if (en_i) begin
         {ce_d, acc_d} = {1'b0, acc_q} + {1'b0, INC};
      end
   end

   // accumulator and registered enable pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         ce_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ce_q  <= ce_d;
      end
   end

   assign ce_o = ce_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: qualifies the PLL lock over a stable window,
// holds the downstream reset for a fixed time, releases it, and watches
// for filtered lock loss. Also generates the ~2 MHz clock enable while
// running.
module clk_rst_seq
   import clk_rst_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES = 4096,
   parameter int unsigned RST_HOLD_CYCLES    = 16,
   parameter int unsigned LOSS_FILTER        = 4,
   parameter int unsigned ACC_W              = ACC_W_DEF,
   parameter int unsigned CE_INC             = CE_INC_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       sys_rst_n,
   output logic       ce_2m,
   output logic       lock_lost,
   output logic [7:0] lock_loss_cnt
);

   // counters only ever hold 0..N-1; the +1 keeps the width nonzero at N=1
   localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned HLD_W = $clog2(RST_HOLD_CYCLES + 1);
   localparam int unsigned LOS_W = $clog2(LOSS_FILTER + 1);

   localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [LOS_W-1:0] LOS_LAST = LOS_W'(LOSS_FILTER - 1);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic             sync1_q;
   logic             lk_q;
   seq_state_e       state_q;
   logic [STB_W-1:0] stable_q;
   logic [HLD_W-1:0] hold_q;
   logic [LOS_W-1:0] loss_q;
   logic             sys_rst_n_q;
   logic             lock_lost_q;
   logic [7:0]       loss_cnt_q;
   logic             loss_hit;
   logic             ce_en;

   // filtered loss fires on the last qualifying unlocked RUN cycle
   assign loss_hit = (state_q == RUN) && !lk_q && (loss_q == LOS_LAST);
   // accumulator runs only in cycles that stay in RUN, so no pulse can
   // appear on the cycle after leaving RUN
   assign ce_en    = (state_q == RUN) && !loss_hit;

   // two-flop synchroniser for the asynchronous lock indication
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         lk_q    <= 1'b0;
      end else begin
         sync1_q <= pll_locked;
         lk_q    <= sync1_q;
      end
   end

   // sequencer FSM with registered reset output and loss bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= WAIT_LOCK;
         stable_q    <= '0;
         hold_q      <= '0;
         loss_q      <= '0;
         sys_rst_n_q <= 1'b0;
         lock_lost_q <= 1'b0;
         loss_cnt_q  <= '0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               hold_q      <= '0;
               loss_q      <= '0;
               sys_rst_n_q <= 1'b0;
               if (!lk_q) begin
                  stable_q <= '0;
               end else if (stable_q == STB_LAST) begin
                  stable_q <= '0;
                  state_q  <= HOLD;
               end else begin
                  stable_q <= stable_q + STB_W'(1);
               end
            end
            HOLD: begin
               if (!lk_q) begin
                  hold_q   <= '0;
                  stable_q <= '0;
                  state_q  <= WAIT_LOCK;
               end else if (hold_q == HLD_LAST) begin
                  hold_q      <= '0;
                  state_q     <= RUN;
                  sys_rst_n_q <= 1'b1;
               end else begin
                  hold_q <= hold_q + HLD_W'(1);
               end
            end
            RUN: begin
               if (loss_hit) begin
                  loss_q      <= '0;
                  state_q     <= WAIT_LOCK;
                  sys_rst_n_q <= 1'b0;
                  lock_lost_q <= 1'b1;
                  loss_cnt_q  <= sat_inc8(loss_cnt_q);
               end else if (!lk_q) begin
                  loss_q <= loss_q + LOS_W'(1);
               end else begin
                  loss_q <= '0;
               end
            end
            default: begin
               state_q     <= WAIT_LOCK;
               stable_q    <= '0;
               hold_q      <= '0;
               loss_q      <= '0;
               sys_rst_n_q <= 1'b0;
            end
         endcase
      end
   end

   clk_ce_gen #(
      .ACC_W  (ACC_W),
      .CE_INC (CE_INC)
   ) u_ce_gen (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (ce_en),
      .ce_o   (ce_2m)
   );

   assign sys_rst_n     = sys_rst_n_q;
   assign lock_lost     = lock_lost_q;
   assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq with LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4,
// LOSS_FILTER=3 and the default accumulator settings.
module tb_clk_rst_seq;

   logic       clk;
   logic       rst_n;
   logic       pll_locked;
   logic       sys_rst_n;
   logic       ce_2m;
   logic       lock_lost;
   logic [7:0] lock_loss_cnt;

   int checks = 0;
   int errors = 0;

   clk_rst_seq #(
      .LOCK_STABLE_CYCLES (8),
      .RST_HOLD_CYCLES    (4),
      .LOSS_FILTER        (3),
      .ACC_W              (16),
      .CE_INC             (2796)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .sys_rst_n     (sys_rst_n),
      .ce_2m         (ce_2m),
      .lock_lost     (lock_lost),
      .lock_loss_cnt (lock_loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic pll;
      int   n;
      logic exp_rst;
      logic exp_ce;
      logic exp_lost;
      int   exp_cnt;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // advance n rising edges and settle 1ns after the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic pll);
      pll_locked = pll;
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
   endtask

   task automatic wait_rst(input logic lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (sys_rst_n == lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int viol;
      int pulses;
      int adj;
      int early;
      int timeouts;
      logic ce_prev;

      // edge numbers count rising edges after rst_n release
      vecs[0]  = '{1'b1, 13, 1'b0, 1'b0, 1'b0, 0};  // edge 13: still in HOLD
      vecs[1]  = '{1'b1,  1, 1'b1, 1'b0, 1'b0, 0};  // edge 14 = 2+8+4: RUN
      vecs[2]  = '{1'b1,  5, 1'b1, 1'b0, 1'b0, 0};  // edge 19
      vecs[3]  = '{1'b0,  2, 1'b1, 1'b0, 1'b0, 0};  // start 2-cycle glitch
      vecs[4]  = '{1'b1,  6, 1'b1, 1'b0, 1'b0, 0};  // glitch ignored
      vecs[5]  = '{1'b0,  3, 1'b1, 1'b0, 1'b0, 0};  // 3-cycle drop, edge 30
      vecs[6]  = '{1'b1,  1, 1'b1, 1'b0, 1'b0, 0};  // edge 31: 2 lk=0 seen
      vecs[7]  = '{1'b1,  1, 1'b0, 1'b0, 1'b1, 1};  // edge 32: loss taken
      vecs[8]  = '{1'b1, 11, 1'b0, 1'b0, 1'b1, 1};  // edge 43: HOLD
      vecs[9]  = '{1'b1,  1, 1'b1, 1'b0, 1'b1, 1};  // edge 44: RUN again
      vecs[10] = '{1'b0,  5, 1'b0, 1'b0, 1'b1, 2};  // edge 49: 2nd loss
      vecs[11] = '{1'b1, 10, 1'b0, 1'b0, 1'b1, 2};  // edge 59: enter HOLD
      vecs[12] = '{1'b0,  6, 1'b0, 1'b0, 1'b1, 2};  // HOLD abort, no loss
      vecs[13] = '{1'b1, 13, 1'b0, 1'b0, 1'b1, 2};  // edge 78: HOLD
      vecs[14] = '{1'b1,  1, 1'b1, 1'b0, 1'b1, 2};  // edge 79: RUN

      // reset state
      pll_locked = 1'b1;
      rst_n = 1'b0;
      step(3);
      chk("reset_sys_rst_n", int'(sys_rst_n), 0);
      chk("reset_ce_2m", int'(ce_2m), 0);
      chk("reset_lock_lost", int'(lock_lost), 0);
      chk("reset_lock_loss_cnt", int'(lock_loss_cnt), 0);
      rst_n = 1'b1;

      // table-driven sequence: cold start, glitch filter, losses, HOLD abort
      for (int v = 0; v < 15; v++) begin
         pll_locked = vecs[v].pll;
         step(vecs[v].n);
         chk($sformatf("vec%0d_sys_rst_n", v), int'(sys_rst_n), int'(vecs[v].exp_rst));
         chk($sformatf("vec%0d_ce_2m", v), int'(ce_2m), int'(vecs[v].exp_ce));
         chk($sformatf("vec%0d_lock_lost", v), int'(lock_lost), int'(vecs[v].exp_lost));
         chk($sformatf("vec%0d_lock_loss_cnt", v), int'(lock_loss_cnt), vecs[v].exp_cnt);
      end

      // third loss, then requalify into HOLD and pulse rst_n mid-HOLD
      pll_locked = 1'b0;
      step(6);
      chk("third_loss_cnt", int'(lock_loss_cnt), 3);
      pll_locked = 1'b1;
      step(11);
      chk("midhold_sys_rst_n", int'(sys_rst_n), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sys_rst_n", int'(sys_rst_n), 0);
      chk("async_rst_ce_2m", int'(ce_2m), 0);
      chk("async_rst_lock_lost", int'(lock_lost), 0);
      chk("async_rst_lock_loss_cnt", int'(lock_loss_cnt), 0);
      step(1);
      rst_n = 1'b1;
      step(13);
      chk("requal_edge13_sys_rst_n", int'(sys_rst_n), 0);
      step(1);
      chk("requal_edge14_sys_rst_n", int'(sys_rst_n), 1);

      // lock chatter: 5 cycles high / 5 low never qualifies
      do_reset(1'b0);
      viol = 0;
      for (int i = 0; i < 120; i++) begin
         pll_locked = ((i / 5) % 2) == 1;
         step(1);
         if (sys_rst_n !== 1'b0) viol++;
      end
      chk("chatter_sys_rst_n_high_cycles", viol, 0);
      chk("chatter_lock_loss_cnt", int'(lock_loss_cnt), 0);
      chk("chatter_lock_lost", int'(lock_lost), 0);

      // clock-enable rate over 65536 RUN cycles
      do_reset(1'b1);
      early = 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (sys_rst_n === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (ce_2m !== 1'b0) early++;
      end
      chk("ce_run_reached", int'(ok), 1);
      chk("ce_before_run", early, 0);
      chk("ce_first_run_cycle", int'(ce_2m), 0);
      pulses = 0;
      adj = 0;
      viol = 0;
      ce_prev = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         step(1);
         if (ce_2m === 1'b1) pulses++;
         if (ce_2m === 1'b1 && ce_prev === 1'b1) adj++;
         if (sys_rst_n !== 1'b1) viol++;
         ce_prev = ce_2m;
      end
      chk("ce_pulse_count", pulses, 2796);
      chk("ce_adjacent_pulses", adj, 0);
      chk("ce_run_dropped", viol, 0);

      // 300 filtered losses saturate the counter at 255
      do_reset(1'b1);
      timeouts = 0;
      for (int i = 1; i <= 300; i++) begin
         pll_locked = 1'b1;
         wait_rst(1'b1, 40, ok);
         if (!ok) timeouts++;
         pll_locked = 1'b0;
         wait_rst(1'b0, 20, ok);
         if (!ok) timeouts++;
         if (i == 1) chk("sat_cnt_after_1", int'(lock_loss_cnt), 1);
         if (i == 254) chk("sat_cnt_after_254", int'(lock_loss_cnt), 254);
         if (i == 255) chk("sat_cnt_after_255", int'(lock_loss_cnt), 255);
      end
      chk("sat_wait_timeouts", timeouts, 0);
      chk("sat_cnt_after_300", int'(lock_loss_cnt), 255);
      chk("sat_lock_lost", int'(lock_lost), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 4096: consecutive synchronised-locked cycles required before reset release.
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 16: cycles sys_rst_n is held low after lock qualifies.
REQ-003 SHALL have parameter LOSS_FILTER, default 4: consecutive synchronised-unlocked cycles that count as a lock loss.
REQ-004 SHALL have parameter ACC_W, default 16: clock-enable phase-accumulator width.
REQ-005 SHALL have parameter CE_INC, default 2796: accumulator increment; 2796/65536 × 46.875 MHz ≈ 2.0 MHz.
REQ-006 SHALL have port clk, input, 1 bit: single clock (46.875 MHz PLL output); all state is in this domain.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to clk.
REQ-009 SHALL have port sys_rst_n, output, 1 bit: downstream reset, active-low, asserted asynchronously, deasserted synchronously.
REQ-010 SHALL have port ce_2m, output, 1 bit: one-cycle clock-enable pulse, average rate CE_INC/2^ACC_W × f_clk.
REQ-011 SHALL have port lock_lost, output, 1 bit: sticky flag, set on first filtered lock loss.
REQ-012 SHALL have port lock_loss_cnt, output, 8 bits: count of filtered lock losses, saturating.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchroniser; all logic uses the synchronised value lk.
REQ-014 SHALL implement states WAIT_LOCK, HOLD, RUN.
REQ-015 WAIT_LOCK: stable counter increments while lk=1 and clears to 0 on any lk=0 cycle; enter HOLD on the cycle the counter reaches LOCK_STABLE_CYCLES-1 with lk=1.
REQ-016 HOLD: sys_rst_n=0; hold counter runs RST_HOLD_CYCLES cycles, then enter RUN; if lk=0 during HOLD, return to WAIT_LOCK with counters cleared and no loss counted.
REQ-017 RUN: sys_rst_n=1 from the first RUN cycle (registered output).
REQ-018 RUN: loss counter increments while lk=0 and clears on lk=1; on reaching LOSS_FILTER: enter WAIT_LOCK, set lock_lost, increment lock_loss_cnt; lk=0 pulses shorter than LOSS_FILTER are ignored.
REQ-019 lock_loss_cnt SHALL saturate at 255; lock_lost and lock_loss_cnt clear only on rst_n.
REQ-020 sys_rst_n SHALL be 0 in WAIT_LOCK and HOLD, and go 0 on the clock edge of the RUN→WAIT_LOCK transition.
REQ-021 Accumulator SHALL add CE_INC modulo 2^ACC_W each RUN cycle; ce_2m=1 (registered) for the one cycle following each carry-out.
REQ-022 Outside RUN, accumulator SHALL be held at 0 and ce_2m=0; no ce_2m pulse SHALL occur in the cycle sys_rst_n first goes 1.
REQ-023 Counter widths SHALL be derived with clog2 from parameters; no truncation at parameter maxima.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state WAIT_LOCK, synchroniser flops 0, all counters 0, sys_rst_n=0, ce_2m=0, lock_lost=0, lock_loss_cnt=0.
REQ-025 After rst_n deasserts, the block SHALL restart qualification from WAIT_LOCK regardless of pll_locked level.

Structure
REQ-026 State encoding and the default increment constant SHALL live in shared package clk_rst_pkg.
REQ-027 Sub-module clk_ce_gen (phase accumulator plus ce register) SHALL be instantiated once; the remainder stays flat.

Verification (LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, LOSS_FILTER=3 unless stated)
REQ-028 Cold start: pll_locked=1 from cycle 0 → sys_rst_n rises at cycle 2+8+4 (±1 per RTL-documented edge), then ce_2m pulses start.
REQ-029 Lock chatter: pll_locked toggling every 5 cycles → sys_rst_n stays 0, lock_loss_cnt=0.
REQ-030 Glitch filter: in RUN, pll_locked low for 2 cycles → no change; low for 3 cycles → sys_rst_n=0, lock_lost=1, lock_loss_cnt=1.
REQ-031 CE rate: 65536 RUN cycles with defaults → exactly 2796 ce_2m pulses, each 1 cycle wide, never adjacent.
REQ-032 Saturation and reset: 300 filtered losses → lock_loss_cnt=255; rst_n pulse mid-HOLD → all outputs 0 immediately, requalification restarts.
